// File: rtl/cic_pkg.sv
// cic_pkg: shared helpers for the CIC decimator.
//   cic_acc_width() - accumulator width needed for a given input width, order
//                     and ratio-input width (bit growth of ORDER*log2(Rmax)).
//   CIC_SHIFT_W     - shift-control width for the default configuration.
//   sat_to()        - clamps a wide signed value to a signed field of 'width'
//                     bits and reports whether it clipped.
// The optional macro CIC_ROUND_EN (used in cic_decimator) is not referenced here.
package cic_pkg;

    // Working width for the output stage; must exceed any ACC_W in use.
    localparam int CIC_MAX_W = 256;

    function automatic int cic_acc_width(input int in_w, input int order, input int ratio_w);
        return in_w + order * ratio_w;
    endfunction

    localparam int CIC_DEF_ACC_W = cic_acc_width(8, 5, 16);
    localparam int CIC_SHIFT_W   = $clog2(CIC_DEF_ACC_W);

    function automatic logic signed [CIC_MAX_W-1:0] sat_to(
        input  logic signed [CIC_MAX_W-1:0] x,
        input  int                          width,
        output logic                        clipped
    );
        logic signed [CIC_MAX_W-1:0] hi;
        logic signed [CIC_MAX_W-1:0] lo;
        hi      = $signed((CIC_MAX_W'(1) << (width - 1)) - CIC_MAX_W'(1));
        lo      = ~hi;  // -(2^(width-1))
        clipped = 1'b0;
        sat_to  = x;
        if (x > hi) begin
            sat_to  = hi;
            clipped = 1'b1;
        end else if (x < lo) begin
            sat_to  = lo;
            clipped = 1'b1;
        end
    endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// cic_comb_stage: one CIC comb (differentiator) section, differential delay 1.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   in_valid, in_data   - token and sample from the previous section
//   out_valid, out_data - registered token and difference x - x_prev
// The stage only advances when a token is present, so the delay register
// holds the previous decimated sample, not the previous clock's value.
module cic_comb_stage #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data
);

    logic [W-1:0] prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= in_data - prev;
                prev     <= in_data;
            end
        end
    end

endmodule

// File: rtl/cic_decimator.sv
// cic_decimator: ORDER-stage CIC decimator with runtime ratio and shift,
// saturating signed output.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   ratio      - decimation ratio R (0 behaves as 1), latched at each output
//                period boundary and during reset
//   shift      - arithmetic right shift before saturation, latched like ratio
//   in_valid   - in_data carries a new sample this cycle
//   in_data    - signed input sample
//   out_valid  - one-cycle strobe per decimated sample
//   out_data   - signed output, held between strobes
//   sat        - set with out_valid when that sample was clipped
// Stream semantics: a transfer happens on every clock edge where the valid
// bit is high; there is no ready, the block never stalls its source and the
// consumer must take every out_valid strobe.
// Optional build macro: CIC_ROUND_EN - round half up before the shift
// (default: truncate toward minus infinity).
module cic_decimator
    import cic_pkg::*;
#(
    parameter int ORDER   = 5,
    parameter int IN_W    = 8,
    parameter int OUT_W   = 8,
    parameter int RATIO_W = 16,
    parameter int ACC_W   = cic_acc_width(IN_W, ORDER, RATIO_W)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [RATIO_W-1:0]       ratio,
    input  logic [$clog2(ACC_W)-1:0] shift,
    input  logic                     in_valid,
    input  logic [IN_W-1:0]          in_data,
    output logic                     out_valid,
    output logic [OUT_W-1:0]         out_data,
    output logic                     sat
);

    localparam int SHIFT_W = $clog2(ACC_W);

    // ---------------- integrators ----------------
    logic [ACC_W-1:0] integ [1:ORDER];

    // Every stage adds the previous stage's pre-edge value, so a sample moves
    // one stage per accepted input. Wrap-around modulo 2^ACC_W is intended.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 1; k <= ORDER; k++) integ[k] <= '0;
        end else if (in_valid) begin
            integ[1] <= integ[1] + {{(ACC_W-IN_W){in_data[IN_W-1]}}, in_data};
            for (int k = 2; k <= ORDER; k++) integ[k] <= integ[k] + integ[k-1];
        end
    end

    // ---------------- decimation counter ----------------
    logic [RATIO_W-1:0] count;
    logic [RATIO_W-1:0] ratio_q;
    logic [SHIFT_W-1:0] shift_q;
    logic               dec_event;

    assign dec_event = in_valid &&
                       ((ratio_q <= RATIO_W'(1)) || (count == ratio_q - RATIO_W'(1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= '0;
            ratio_q <= ratio;
            shift_q <= shift;
        end else if (in_valid) begin
            if (dec_event) begin
                count   <= '0;
                ratio_q <= ratio;
                shift_q <= shift;
            end else begin
                count <= count + RATIO_W'(1);
            end
        end
    end

    // ---------------- comb chain ----------------
    // cap is the last integrator's pre-edge value; the first comb stage
    // registers it on the decimation event, which keeps event-to-strobe
    // latency at ORDER+1 cycles.
    logic [ACC_W-1:0] cap;
    logic [ACC_W-1:0] c_data  [0:ORDER];
    logic             c_valid [0:ORDER];
    logic [SHIFT_W-1:0] sh_pipe [1:ORDER];

    assign cap        = integ[ORDER];
    assign c_data[0]  = cap;
    assign c_valid[0] = dec_event;

    for (genvar g = 1; g <= ORDER; g++) begin : g_comb
        cic_comb_stage #(.W(ACC_W)) u_stage (
            .clk      (clk),
            .rst      (rst),
            .in_valid (c_valid[g-1]),
            .in_data  (c_data[g-1]),
            .out_valid(c_valid[g]),
            .out_data (c_data[g])
        );
    end

    // The shift in force for the period just ended rides alongside its token,
    // so a reload at the next event cannot affect a sample still in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 1; k <= ORDER; k++) sh_pipe[k] <= '0;
        end else begin
            if (dec_event) sh_pipe[1] <= shift_q;
            for (int k = 2; k <= ORDER; k++) begin
                if (c_valid[k-1]) sh_pipe[k] <= sh_pipe[k-1];
            end
        end
    end

    // ---------------- output stage ----------------
    // Widened first so the rounding offset can never wrap the comb result.
    logic signed [CIC_MAX_W-1:0] wide;
    logic                        clip;
    logic [OUT_W-1:0]            out_next;

    always_comb begin
        wide = CIC_MAX_W'($signed(c_data[ORDER]));
`ifdef CIC_ROUND_EN
        if (sh_pipe[ORDER] != '0) begin
            wide = wide + (CIC_MAX_W'(1) << (sh_pipe[ORDER] - 1'b1));
        end
`endif
        wide     = wide >>> sh_pipe[ORDER];
        out_next = OUT_W'(sat_to(wide, OUT_W, clip));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            sat       <= 1'b0;
        end else begin
            out_valid <= c_valid[ORDER];
            if (c_valid[ORDER]) begin
                out_data <= out_next;
                sat      <= clip;
            end
        end
    end

endmodule

// File: tb/tb_cic_decimator.sv
// tb_cic_decimator: self-checking bench for cic_decimator (ORDER=5, IN_W=8,
// OUT_W=16). Stimulus is a DC level per segment; the reference uses the
// closed form of the integrator cascade for a DC input (last integrator
// before update at accepted sample n equals d*C(n,ORDER)) followed by an
// ORDER-th difference across decimation events, then shift/round/saturate.
module tb_cic_decimator;

    localparam int ORDER   = 5;
    localparam int IN_W    = 8;
    localparam int OUT_W   = 16;
    localparam int RATIO_W = 16;
    localparam int ACC_W   = IN_W + ORDER * RATIO_W;
    localparam int SHIFT_W = $clog2(ACC_W);
    localparam int EW      = OUT_W + 1;

    logic               clk;
    logic               rst;
    logic [RATIO_W-1:0] ratio;
    logic [SHIFT_W-1:0] shift;
    logic               in_valid;
    logic [IN_W-1:0]    in_data;
    logic               out_valid;
    logic [OUT_W-1:0]   out_data;
    logic               sat;

    cic_decimator #(
        .ORDER  (ORDER),
        .IN_W   (IN_W),
        .OUT_W  (OUT_W),
        .RATIO_W(RATIO_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ratio    (ratio),
        .shift    (shift),
        .in_valid (in_valid),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_data (out_data),
        .sat      (sat)
    );

    // ---------------- clock / reset ----------------
    int cyc = 0;
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [EW-1:0] exp_q[$];
    int            exp_cyc_q[$];
    int            d_cur;
    longint        m_n;
    int            m_cnt;
    int            m_rq;
    int            m_sq;
    longint        hist [0:ORDER];

    function automatic longint binom(input longint n, input int k);
        longint r;
        if (n < k) return 0;
        r = 1;
        for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
        return r;
    endfunction

    function automatic logic [EW-1:0] model_event();
        longint y;
        longint hi;
        longint lo;
        logic   s;
        for (int k = ORDER; k >= 1; k--) hist[k] = hist[k-1];
        hist[0] = longint'(d_cur) * binom(m_n, ORDER);
        y = 0;
        for (int k = 0; k <= ORDER; k++) begin
            if (k % 2 == 0) y = y + binom(ORDER, k) * hist[k];
            else            y = y - binom(ORDER, k) * hist[k];
        end
`ifdef CIC_ROUND_EN
        if (m_sq > 0) y = y + (longint'(1) <<< (m_sq - 1));
`endif
        y  = y >>> m_sq;
        hi = (longint'(1) <<< (OUT_W - 1)) - 1;
        lo = -hi - 1;
        s  = 1'b0;
        if (y > hi) begin y = hi; s = 1'b1; end
        else if (y < lo) begin y = lo; s = 1'b1; end
        return {s, y[OUT_W-1:0]};
    endfunction

    task automatic model_reset();
        m_n   = 0;
        m_cnt = 0;
        m_rq  = int'(ratio);
        m_sq  = int'(shift);
        for (int k = 0; k <= ORDER; k++) hist[k] = 0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input bit v, output bit was_evt);
        bit            evt;
        logic [EW-1:0] e;
        in_valid = v;
        in_data  = v ? IN_W'(d_cur) : IN_W'($urandom);
        evt      = 1'b0;
        e        = '0;
        if (v) begin
            evt = (m_rq <= 1) || (m_cnt == m_rq - 1);
            if (evt) e = model_event();
        end
        @(posedge clk);
        #1;
        if (v) begin
            if (evt) begin
                exp_q.push_back(e);
                exp_cyc_q.push_back(cyc + ORDER);
                m_cnt = 0;
                m_rq  = int'(ratio);
                m_sq  = int'(shift);
            end else begin
                m_cnt++;
            end
            m_n++;
        end
        in_valid = 1'b0;
        was_evt  = evt;
    endtask

    task automatic do_reset(input int n);
        in_valid = 1'b0;
        rst      = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        check("rst out_valid", longint'(out_valid), 0);
        check("rst out_data", longint'(out_data), 0);
        check("rst sat", longint'(sat), 0);
        exp_q.delete();
        exp_cyc_q.delete();
        model_reset();
        rst = 1'b0;
    endtask

    task automatic drain();
        bit dummy;
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < ORDER + 20) begin
            drive(1'b0, dummy);
            guard++;
        end
        check("drain pending outputs", longint'(exp_q.size()), 0);
    endtask

    task automatic run_seg(input int d, input int r, input int s, input int nsamp, input int gap);
        bit dummy;
        d_cur = d;
        ratio = RATIO_W'(r);
        shift = SHIFT_W'(s);
        do_reset(2);
        for (int i = 0; i < nsamp; i++) begin
            drive(1'b1, dummy);
            repeat (gap) drive(1'b0, dummy);
        end
        drain();
    endtask

    // ---------------- scoreboard monitor ----------------
    longint last_out = 0;
    longint last_sat = 0;

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious out_valid", longint'(out_valid), 0);
            end else begin
                logic [EW-1:0] e;
                int            ec;
                e  = exp_q.pop_front();
                ec = exp_cyc_q.pop_front();
                check("out_data", longint'($signed(out_data)), longint'($signed(e[OUT_W-1:0])));
                check("sat", longint'(sat), longint'(e[OUT_W]));
                check("latency", longint'(cyc), longint'(ec));
                last_out = longint'($signed(out_data));
                last_sat = longint'(sat);
            end
        end
    end

    // ---------------- test sequence ----------------
    initial begin
        bit ev;
        int n_ev;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        ratio    = RATIO_W'(4);
        shift    = '0;
        d_cur    = 1;
        do_reset(3);

        // DC gain R^ORDER
        run_seg(1, 4, 0, 48, 0);
        check("dc gain settled", last_out, 1024);
        check("dc gain sat", last_sat, 0);

        // saturation at both rails, and the exact negative rail unclipped
        run_seg(1, 8, 0, 80, 0);
        check("sat high value", last_out, 32767);
        check("sat high flag", last_sat, 1);
        run_seg(-1, 8, 0, 80, 0);
        check("neg rail value", last_out, -32768);
        check("neg rail flag", last_sat, 0);
        run_seg(-2, 8, 0, 80, 0);
        check("sat low value", last_out, -32768);
        check("sat low flag", last_sat, 1);

        // rounding versus truncation
        run_seg(1, 4, 11, 48, 0);
`ifdef CIC_ROUND_EN
        check("round settled", last_out, 1);
`else
        check("trunc settled", last_out, 0);
`endif

        // gapped input, 1 of 3 cycles
        run_seg(1, 2, 0, 20, 2);
        check("gapped settled", last_out, 32);

        // ratio 0 and 1: an event on every sample
        run_seg(1, 0, 0, 12, 0);
        check("ratio0 settled", last_out, 1);
        run_seg(3, 1, 0, 12, 0);
        check("ratio1 settled", last_out, 3);

        // ratio change 4 -> 8 in the middle of a period
        d_cur = 1;
        ratio = RATIO_W'(4);
        shift = SHIFT_W'(1);
        do_reset(2);
        for (int i = 0; i < 10; i++) drive(1'b1, ev);
        ratio = RATIO_W'(8);
        for (int i = 0; i < 80; i++) drive(1'b1, ev);
        drain();
        check("ratio change settled", last_out, 16384);

        // reset one cycle after a decimation event
        d_cur = 1;
        ratio = RATIO_W'(4);
        shift = '0;
        do_reset(2);
        n_ev = 0;
        while (n_ev < 3) begin
            drive(1'b1, ev);
            if (ev) n_ev++;
        end
        do_reset(1);
        for (int i = 0; i < 12; i++) drive(1'b0, ev);
        for (int i = 0; i < 48; i++) drive(1'b1, ev);
        drain();
        check("post reset settled", last_out, 1024);

        // random segments
        for (int t = 0; t < 4; t++) begin
            d_cur = int'($urandom_range(0, 6)) - 3;
            ratio = RATIO_W'($urandom_range(1, 6));
            shift = SHIFT_W'($urandom_range(0, 6));
            do_reset(2);
            for (int i = 0; i < int'(ratio) * 8; i++) begin
                drive(1'b1, ev);
                repeat ($urandom_range(0, 2)) drive(1'b0, ev);
            end
            drain();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
